// File: rtl/hash_pkg.sv
// Shared definitions for the hash pipeline output stage: default widths and
// the unpacker FSM state type.
package hash_pkg;

  localparam int HASH_WORD_W = 256;
  localparam int HASH_BEAT_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } unpack_state_t;

endpackage

// File: rtl/hash_word_holding_reg.sv
// Single-entry pending-word register with a valid flag; load wins over clear.
module hash_word_holding_reg #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] word,
  output logic [W-1:0] held_word,
  output logic         held_valid
);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      held_word  <= '0;
      held_valid <= 1'b0;
    end else if (load) begin
      held_word  <= word;
      held_valid <= 1'b1;
    end else if (clear) begin
      held_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/hash_word_unpacker.sv
// Splits full-width hash words into narrow beats, LSB beat first, with a
// one-word pending buffer. Define HASH_UNPACK_PARITY_EN for registered beat parity.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never drops and data never changes until that transfer occurs.
module hash_word_unpacker
  import hash_pkg::*;
#(
  parameter int P_IN_WIDTH  = HASH_WORD_W,
  parameter int P_OUT_WIDTH = HASH_BEAT_W
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [P_IN_WIDTH-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [P_OUT_WIDTH-1:0] out_data,
  output logic                   out_last,
  output logic                   out_parity
);

  localparam int N_BEATS = P_IN_WIDTH / P_OUT_WIDTH;
  localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  generate
    if ((N_BEATS < 2) || ((P_IN_WIDTH % P_OUT_WIDTH) != 0)) begin : g_bad_cfg
      $error("hash_word_unpacker: P_IN_WIDTH must be a multiple (>=2x) of P_OUT_WIDTH");
    end
  endgenerate

  unpack_state_t         state;
  logic [P_IN_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      beat_cnt;
  logic [P_IN_WIDTH-1:0] pend_word;
  logic                  pend_valid;

  logic                   in_fire;
  logic                   out_fire;
  logic                   last_fire;
  logic                   pend_load;
  logic                   pend_clear;
  logic                   pend_valid_next;
  logic                   take_word;
  logic                   step_beat;
  logic                   go_idle;
  logic [P_IN_WIDTH-1:0]  word_src;
  logic [P_OUT_WIDTH-1:0] next_beat;

  always_comb begin
    in_fire    = in_valid && in_ready;
    out_fire   = out_valid && out_ready;
    last_fire  = out_fire && out_last;

    // A word arriving while beats are outstanding parks in the pending
    // register, unless the last beat leaves this same cycle (bypass load).
    pend_load  = in_fire && (state == SEND) && !last_fire;
    pend_clear = last_fire && pend_valid;
    pend_valid_next = pend_load || (pend_valid && !pend_clear);

    take_word  = ((state == IDLE) && in_fire) ||
                 (last_fire && (pend_valid || in_fire));
    step_beat  = out_fire && !out_last;
    go_idle    = last_fire && !pend_valid && !in_fire;

    word_src   = pend_valid ? pend_word : in_data;
    next_beat  = take_word ? word_src[P_OUT_WIDTH-1:0]
                           : shift_reg[P_OUT_WIDTH-1:0];
  end

  hash_word_holding_reg #(
    .W(P_IN_WIDTH)
  ) u_pending (
    .clk       (clk),
    .rstN      (rstN),
    .load      (pend_load),
    .clear     (pend_clear),
    .word      (in_data),
    .held_word (pend_word),
    .held_valid(pend_valid)
  );

  // shift_reg holds the beats not yet presented; out_data is the current beat.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state     <= IDLE;
      shift_reg <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      in_ready <= !pend_valid_next;
      case (state)
        IDLE: begin
          if (take_word) begin
            shift_reg <= word_src >> P_OUT_WIDTH;
            out_data  <= next_beat;
            beat_cnt  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (take_word) begin
            shift_reg <= word_src >> P_OUT_WIDTH;
            out_data  <= next_beat;
            beat_cnt  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b1;
          end else if (step_beat) begin
            shift_reg <= shift_reg >> P_OUT_WIDTH;
            out_data  <= next_beat;
            beat_cnt  <= beat_cnt + 1'b1;
            out_last  <= (beat_cnt == CNT_W'(N_BEATS - 2));
          end else if (go_idle) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HASH_UNPACK_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rstN) begin
      out_parity <= 1'b0;
    end else if (take_word || step_beat) begin
      out_parity <= ^next_beat;
    end
  end
`else
  assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_hash_word_unpacker.sv
// Bench for hash_word_unpacker (64-bit words, 16-bit beats): directed steps
// plus random traffic checked against a beat-queue reference model.
module tb_hash_word_unpacker;

  localparam int IW = 64;
  localparam int OW = 16;
  localparam int NB = IW / OW;

  logic          clk = 1'b0;
  logic          rstN;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          out_parity;

  int checks = 0;
  int errors = 0;

  // Expected beats in order: {last, data}.
  logic [OW:0] exp_q[$];

  always #5 clk = ~clk;

  hash_word_unpacker #(
    .P_IN_WIDTH (IW),
    .P_OUT_WIDTH(OW)
  ) dut (
    .clk       (clk),
    .rstN      (rstN),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_parity(out_parity)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Words held by the unpacker = words whose last beat has not left yet.
  function automatic int words_held();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i][OW]) n++;
    return n;
  endfunction

  task automatic push_word(input logic [IW-1:0] w);
    for (int k = 0; k < NB; k++)
      exp_q.push_back({(k == NB - 1), w[k*OW +: OW]});
  endtask

  // One cycle: drive, check outputs at the falling edge, update the model.
  task automatic step(input logic iv, input logic [IW-1:0] d, input logic ordy);
    int  n;
    logic in_fire, out_fire;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    n = words_held();
    chk("out_valid", 64'(out_valid), 64'(n >= 1));
    chk("in_ready", 64'(in_ready), 64'(n < 2));
    if (n >= 1) begin
      chk("out_data", 64'(out_data), 64'(exp_q[0][OW-1:0]));
      chk("out_last", 64'(out_last), 64'(exp_q[0][OW]));
`ifdef HASH_UNPACK_PARITY_EN
      chk("out_parity", 64'(out_parity), 64'(^exp_q[0][OW-1:0]));
`endif
    end
`ifndef HASH_UNPACK_PARITY_EN
    chk("out_parity_off", 64'(out_parity), 64'(0));
`endif
    in_fire  = iv && (n < 2);
    out_fire = (n >= 1) && ordy;
    @(posedge clk);
    if (out_fire) void'(exp_q.pop_front());
    if (in_fire) push_word(d);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(1'b0, '0, 1'b1);
    chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    step(1'b0, '0, 1'b1);
  endtask

  task automatic do_reset();
    rstN      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_out_parity", 64'(out_parity), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // Single word, free-flowing output.
    step(1'b1, 64'h4444_3333_2222_1111, 1'b1);
    drain();

    // Two back-to-back words: second parks in the pending register.
    step(1'b1, 64'h8888_7777_6666_5555, 1'b1);
    step(1'b1, 64'hCCCC_BBBB_AAAA_9999, 1'b1);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    drain();

    // Output stall in the middle of a word.
    step(1'b1, 64'hDDDD_CCCC_BBBB_AAAA, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    drain();

    // New word offered exactly on the last-beat cycle with nothing pending.
    step(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b1, 64'h0F0F_F0F0_00FF_FF00, 1'b1);
    drain();

    // Parity pattern: beats 0x0001, 0x0003, 0, 0.
    step(1'b1, 64'h0000_0000_0003_0001, 1'b1);
    drain();

    // Reset mid-word with a second word pending.
    step(1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1);
    step(1'b1, 64'h1111_2222_3333_4444, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    do_reset();
    step(1'b1, 64'h0004_0003_0002_0001, 1'b1);
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 2) != 0), {$urandom, $urandom},
           1'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
